piso_frame: RTL and testbench
=============================

// Module: piso_frame
// PURPOSE
// - Parallel-in serial-out transmitter; the counterpart of the trickle-in sipo.
// - Accepts width_p-bit words over ready/valid and emits them one bit at a time
//   over valid/yumi.
// - Groups depth_p words into a frame and marks the final bit with last_o.
// - Drains systolic_array / fifo results as a bit stream toward an LED,
//   PMOD pin or a loop-back sipo.
// PARAMETERS
// - width_p      8   bits per word
// - depth_p      4   words per frame (equals num_macs_p at top level); >=1
// - msb_first_p  1   1: bit [width_p-1] is sent first; 0: bit [0] is sent first
// PORTS
// - clk_i      in   1        single clock; all logic is posedge clk_i
// - reset_n_i  in   1        asynchronous, active-low reset
// - flush_i    in   1        synchronous abort of the current word and frame
// - ready_o    out  1        able to accept a word this cycle
// - valid_i    in   1        data_i is valid
// - data_i     in   width_p  parallel word
// - valid_o    out  1        data_o holds a bit
// - data_o     out  1        serial bit
// - yumi_i     in   1        consumer takes data_o this cycle; legal only when valid_o=1
// - last_o     out  1        data_o is the final bit of the final word of the frame
// - busy_o     out  1        a word is being shifted out (valid_o=1)
// BEHAVIOUR
// - Reset: reset_n_i=0 immediately forces the following, regardless of clk_i:
//   state=IDLE, ready_o=1, valid_o=0, data_o=0, last_o=0, busy_o=0, bit_cnt=0, word_cnt=0.
// - State IDLE:
//   - ready_o = ~flush_i.
//   - valid_i & ready_o loads the shift register and moves to SHIFT.
// - State SHIFT:
//   - valid_o=1, busy_o=1; data_o is the current head bit.
//   - yumi_i=1 advances the shift register and increments bit_cnt.
// - Latency: a word accepted in cycle N has its first bit on data_o in cycle N+1.
// - Back-pressure: while valid_o & ~yumi_i, data_o and last_o hold stable.
// - Zero-bubble streaming:
//   - In SHIFT, ready_o = yumi_i & (bit_cnt==width_p-1) & ~flush_i
//     (combinational from yumi_i).
//   - A word loaded in that cycle stays in SHIFT with bit_cnt=0.
//   - With no new word in that cycle, the block returns to IDLE.
// - Word and frame counting:
//   - word_cnt increments when the last bit of a word is yumi'd.
//   - word_cnt wraps to 0 after depth_p-1.
//   - word_cnt is retained across IDLE gaps, so a frame may be spread over time.
// - last_o = valid_o & (bit_cnt==width_p-1) & (word_cnt==depth_p-1).
// - depth_p=1: every word is a complete frame.
// - flush_i=1, in any state:
//   - Takes priority over valid_i and yumi_i.
//   - Next cycle: state=IDLE, valid_o=0, bit_cnt=0, word_cnt=0.
//   - A bit yumi'd in the flush cycle is considered discarded.
// - yumi_i=1 while valid_o=0 is illegal: it is ignored and flagged by an assertion.
// - valid_i while ready_o=0 is held off; the producer keeps data_i stable, which
//   matches the fifo valid/yumi usage.
// - Widths:
//   - bit_cnt is $clog2(width_p) bits.
//   - word_cnt is $clog2(depth_p) bits, with a minimum of 1.
//   - Counter comparisons are exact; no wrap occurs beyond the terminal count.
// STRUCTURE
// - Shared package systolic_pkg:
//   - typedef enum logic [0:0] {IDLE, SHIFT} piso_state_e
//   - function for the minimum-1 clog2 width
// - One sub-module: up_counter
//   - Parameters: max value and width.
//   - Ports: clk_i, reset_n_i, clear_i, en_i, count_o, wrap_o.
//   - Instantiated twice: bit_cnt and word_cnt.
// - The shift register and FSM stay inline.
// TESTING
// 1. Reset: reset_n_i=0 mid-SHIFT between clock edges
//    -> outputs go to their reset values before the next edge: valid_o=0, ready_o=1,
//       last_o=0; word_cnt=0 afterwards.
// 2. Single word: data_i=8'hA5, msb_first_p=1, yumi_i held 1
//    -> data_o sequence 1,0,1,0,0,1,0,1 in cycles N+1..N+8;
//       ready_o=1 in cycle N+8; valid_o=0 in N+9.
// 3. Back-pressure: 8'h3C with yumi_i toggling 1,0,1,0,...
//    -> each bit is held for 2 cycles; bit order 0,0,1,1,1,1,0,0; no bit lost or duplicated.
// 4. Streaming frame: 8'h01, 8'h02, 8'h03, 8'h04 offered back-to-back, yumi_i=1
//    -> 32 contiguous valid_o cycles; last_o=1 only on bit 32; word_cnt returns to 0.
// 5. Gapped frame: two words, 100 idle cycles, two words
//    -> last_o appears only on bit 32 of the 4th word.
// 6. Flush: flush_i after 3 bits of word 2, with valid_i asserted in the same cycle
//    -> no load; valid_o=0 next cycle; the next word starts a new frame
//       (last_o after 4 more words).
// 7. LSB order: msb_first_p=0, 8'h80 -> data_o sequence 0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic datapath blocks.
package systolic_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Counter width for a range of v values, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/up_counter.sv
// Free-running up counter 0..max_p with synchronous clear and a wrap strobe.
module up_counter #(
    parameter int unsigned max_p   = 7,
    parameter int unsigned width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o,
    output logic               wrap_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_p);

    logic at_max;

    always_comb begin
        at_max = (count_o == max_lp);
        wrap_o = en_i & at_max;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= at_max ? '0 : count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/piso_frame.sv
// Parallel-in serial-out transmitter: words in over ready/valid, bits out over
// valid/yumi, with the final bit of every depth_p-word frame marked by last_o.
module piso_frame
    import systolic_pkg::*;
#(
    parameter int unsigned width_p     = 8,
    parameter int unsigned depth_p     = 4,
    parameter bit          msb_first_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    output logic               ready_o,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               valid_o,
    output logic               data_o,
    input  logic               yumi_i,
    output logic               last_o,
    output logic               busy_o
);

    localparam int unsigned bit_w_lp  = clog2_min1(width_p);
    localparam int unsigned word_w_lp = clog2_min1(depth_p);
    localparam logic [bit_w_lp-1:0]  bit_last_lp  = bit_w_lp'(width_p - 1);
    localparam logic [word_w_lp-1:0] word_last_lp = word_w_lp'(depth_p - 1);

    piso_state_e          state;
    logic [width_p-1:0]   shreg;
    logic [bit_w_lp-1:0]  bit_cnt;
    logic [word_w_lp-1:0] word_cnt;
    logic                 bit_wrap;
    logic                 frame_wrap;
    logic                 take;
    logic                 load;
    logic                 on_last_bit;

    // Handshake decode; ready reopens during the final yumi for zero-bubble streaming.
    always_comb begin
        on_last_bit = (bit_cnt == bit_last_lp);
        take        = (state == SHIFT) & yumi_i & ~flush_i;
        ready_o     = ~flush_i;
        if (state == SHIFT) begin
            ready_o = yumi_i & on_last_bit & ~flush_i;
        end
        load = valid_i & ready_o;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            shreg <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            shreg <= '0;
        end else if (load) begin
            state <= SHIFT;
            shreg <= data_i;
        end else if (take) begin
            shreg <= msb_first_p ? (shreg << 1) : (shreg >> 1);
            if (bit_wrap) begin
                state <= IDLE;
            end
        end
    end

    up_counter #(
        .max_p   (width_p - 1),
        .width_p (bit_w_lp)
    ) u_bit_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (flush_i | load),
        .en_i      (take),
        .count_o   (bit_cnt),
        .wrap_o    (bit_wrap)
    );

    up_counter #(
        .max_p   (depth_p - 1),
        .width_p (word_w_lp)
    ) u_word_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (flush_i),
        .en_i      (bit_wrap),
        .count_o   (word_cnt),
        .wrap_o    (frame_wrap)
    );

    always_comb begin
        valid_o = (state == SHIFT);
        busy_o  = (state == SHIFT);
        data_o  = msb_first_p ? shreg[width_p-1] : shreg[0];
        last_o  = valid_o & on_last_bit & (word_cnt == word_last_lp);
    end

    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> valid_o
    ) else $error("yumi_i asserted while valid_o=0");

    frame_end_marked: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) frame_wrap |-> last_o
    ) else $error("frame completed without last_o");

endmodule

// File: tb/tb_piso_frame.sv
// Randomized and directed bench for piso_frame; MSB- and LSB-first instances share stimulus.
module tb_piso_frame;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         valid_i;
    logic [W-1:0] data_i;
    logic         yumi;
    logic         ready_m, valid_m, data_m, last_m, busy_m;
    logic         ready_l, valid_l, data_l, last_l, busy_l;

    typedef struct {
        bit bm;
        bit bl;
        bit last;
    } bit_t;

    bit_t       q[$];
    bit_t       h;
    bit         ev;
    bit         er;
    int         acc_cnt;
    int         cap_n;
    int         last_cnt;
    int         last_at;
    int         val_cyc;
    logic [7:0] cap_m;
    logic [7:0] cap_l;
    int         ymode;
    bit         tog;
    bit         chk_en;
    int         vectors;
    int         miscompares;

    piso_frame #(.width_p(W), .depth_p(D), .msb_first_p(1'b1)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .ready_o(ready_m),
        .valid_i(valid_i), .data_i(data_i), .valid_o(valid_m), .data_o(data_m),
        .yumi_i(yumi), .last_o(last_m), .busy_o(busy_m)
    );

    piso_frame #(.width_p(W), .depth_p(D), .msb_first_p(1'b0)) dut_lsb (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush), .ready_o(ready_l),
        .valid_i(valid_i), .data_i(data_i), .valid_o(valid_l), .data_o(data_l),
        .yumi_i(yumi), .last_o(last_l), .busy_o(busy_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer: yumi only while a bit is offered, pattern chosen by ymode.
    always @(posedge clk) begin
        bit want;
        #1;
        want = 1'b0;
        if (valid_m) begin
            case (ymode)
                0:       want = 1'b1;
                1:       begin want = tog; tog = ~tog; end
                default: want = ($urandom_range(0, 9) < 7);
            endcase
        end
        yumi = valid_m & want;
    end

    // Reference: a queue of the bits still owed, each tagged with its frame-end flag.
    always @(negedge clk) begin
        if (chk_en) begin
            ev = (q.size() != 0);
            er = !flush && (q.size() == 0 || (q.size() == 1 && yumi));
            check("ready_msb", 32'(ready_m), 32'(er));
            check("ready_lsb", 32'(ready_l), 32'(er));
            check("valid_msb", 32'(valid_m), 32'(ev));
            check("valid_lsb", 32'(valid_l), 32'(ev));
            check("busy_msb", 32'(busy_m), 32'(ev));
            check("busy_lsb", 32'(busy_l), 32'(ev));
            if (ev) begin
                h = q[0];
                check("data_msb", 32'(data_m), 32'(h.bm));
                check("data_lsb", 32'(data_l), 32'(h.bl));
                check("last_msb", 32'(last_m), 32'(h.last));
                check("last_lsb", 32'(last_l), 32'(h.last));
                val_cyc++;
            end else begin
                check("last_idle", 32'(last_m), 32'(0));
            end
            if (flush) begin
                q.delete();
                acc_cnt = 0;
            end else begin
                if (yumi && ev) begin
                    cap_m = {cap_m[6:0], h.bm};
                    cap_l = {cap_l[6:0], h.bl};
                    cap_n++;
                    if (h.last) begin
                        last_cnt++;
                        last_at = cap_n;
                    end
                    void'(q.pop_front());
                end
                if (valid_i && er) begin
                    for (int i = 0; i < int'(W); i++) begin
                        q.push_back('{data_i[int'(W) - 1 - i], data_i[i],
                                      (i == int'(W) - 1) && ((acc_cnt % int'(D)) == int'(D) - 1)});
                    end
                    acc_cnt++;
                end
            end
        end
    end

    task automatic clear_cap();
        cap_n = 0; cap_m = '0; cap_l = '0; last_cnt = 0; last_at = 0; val_cyc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        bit acc;
        int n;
        valid_i = 1'b1;
        data_i  = w;
        n = 0;
        do begin
            @(negedge clk);
            acc = ready_m;
            step();
            n++;
        end while (!acc && n < 1000);
        valid_i = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (valid_m && n < 1000) begin
            step();
            n++;
        end
        check("drain_idle", 32'(valid_m), 32'(0));
    endtask

    task automatic fresh();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; acc_cnt = 0; chk_en = 1'b0;
        rst_n = 1'b0; flush = 1'b0; valid_i = 1'b0; data_i = '0;
        ymode = 0; tog = 1'b0; yumi = 1'b0;
        clear_cap();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_m), 32'(1));
        check("rst_valid", 32'(valid_m), 32'(0));
        check("rst_data", 32'(data_m), 32'(0));
        check("rst_last", 32'(last_m), 32'(0));
        check("rst_busy", 32'(busy_m), 32'(0));
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single word, continuous yumi.
        clear_cap();
        send(8'hA5);
        wait_idle();
        check("t2_bits_msb", 32'(cap_m), 32'h0000_00A5);
        check("t2_bits_lsb", 32'(cap_l), 32'h0000_00A5);
        check("t2_count", 32'(cap_n), 32'd8);

        // Asynchronous reset between edges while shifting.
        send(8'hFF);
        repeat (2) @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("arst_valid", 32'(valid_m), 32'(0));
        check("arst_ready", 32'(ready_m), 32'(1));
        check("arst_last", 32'(last_m), 32'(0));
        check("arst_data", 32'(data_m), 32'(0));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        q.delete();
        acc_cnt = 0;
        chk_en = 1'b1;
        step();

        // Streaming frame straight after reset: word count must have restarted.
        clear_cap();
        ymode = 0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        wait_idle();
        check("t4_bits", 32'(cap_n), 32'd32);
        check("t4_valid_cycles", 32'(val_cyc), 32'd32);
        check("t4_last_cnt", 32'(last_cnt), 32'd1);
        check("t4_last_at", 32'(last_at), 32'd32);

        // Back-pressure with alternating yumi.
        fresh();
        clear_cap();
        ymode = 1;
        tog = 1'b0;
        send(8'h3C);
        wait_idle();
        check("t3_bits_msb", 32'(cap_m), 32'h0000_003C);
        check("t3_bits_lsb", 32'(cap_l), 32'h0000_003C);
        check("t3_valid_cycles", 32'(val_cyc), 32'd16);

        // Gapped frame.
        fresh();
        clear_cap();
        ymode = 0;
        send(8'h11); send(8'h22);
        wait_idle();
        repeat (100) step();
        send(8'h33); send(8'h44);
        wait_idle();
        check("t5_last_cnt", 32'(last_cnt), 32'd1);
        check("t5_last_at", 32'(last_at), 32'd32);

        // Flush three bits into word 2 with a competing valid_i.
        fresh();
        clear_cap();
        send(8'hC3);
        send(8'h5A);
        begin
            int n;
            n = 0;
            while (cap_n < 11 && n < 100) begin
                step();
                n++;
            end
            check("t6_reach", 32'(cap_n), 32'd11);
        end
        flush   = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h96;
        step();
        flush = 1'b0;
        clear_cap();
        send(8'h96); send(8'h69); send(8'hF0);
        check("t6_no_last_yet", 32'(last_cnt), 32'd0);
        send(8'h0F);
        wait_idle();
        check("t6_last_cnt", 32'(last_cnt), 32'd1);
        check("t6_last_at", 32'(last_at), 32'd32);

        // Bit order check on both instances.
        fresh();
        clear_cap();
        send(8'h80);
        wait_idle();
        check("t7_bits_msb", 32'(cap_m), 32'h0000_0080);
        check("t7_bits_lsb", 32'(cap_l), 32'h0000_0001);

        // Random traffic with random yumi, gaps and occasional flushes.
        ymode = 2;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 19) == 0) fresh();
            send(W'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
